// File: rtl/gray_sched_pkg.sv
// Shared types and constants for the gray-counter step scheduler.
`timescale 1ns/100ps
package gray_sched_pkg;

    localparam int W_DEF     = 3;
    localparam int LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // Last gray code before the counter rolls back to zero (e.g. 3'b100 for W=3).
    function automatic int unsigned gray_max(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    localparam logic [W_DEF-1:0] GRAY_MAX = W_DEF'(gray_max(W_DEF));

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-served pointer advances only on accept.
`timescale 1ns/100ps
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant  = 2'b00;
        last_d = last_q;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (accept) begin
            last_d = grant[1];
        end
    end

    // Pointer holds the index served last; resetting it to 1 gives req0 first priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/gray_step_sched.sv
// Two-requester scheduler that owns the enable/clear of a shared gray counter.
`timescale 1ns/100ps
module gray_step_sched
    import gray_sched_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       Req_valid,
    input  logic [2*LEN_W-1:0] Req_len,
    output logic [1:0]       Req_ready,
    output logic             Cnt_en,
    output logic             Cnt_clr,
    input  logic [W-1:0]     Cnt_val,
    output logic             Busy,
    output logic             Done,
    output logic             Done_id,
    output logic [LEN_W-1:0] Wraps
);

    localparam logic [W-1:0]     GRAY_TOP = W'(gray_max(W));
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             id_q, id_d;
    logic [LEN_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             done_id_q, done_id_d;
    logic [LEN_W-1:0] wraps_q, wraps_d;

    logic [1:0]       grant;
    logic             accept;
    logic             win_id;
    logic [LEN_W-1:0] win_len;

    rr_arb2 u_arb (
        .clk    (Clk),
        .reset  (Reset),
        .valid  (Req_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign Req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
    assign accept    = |(Req_valid & Req_ready);
    assign win_id    = grant[1];
    assign win_len   = win_id ? Req_len[2*LEN_W-1:LEN_W] : Req_len[LEN_W-1:0];

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        id_d       = id_q;
        wrap_cnt_d = wrap_cnt_q;
        done_id_d  = done_id_q;
        wraps_d    = wraps_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d       = win_id;
                    rem_d      = win_len;
                    wrap_cnt_d = '0;
                    state_d    = (win_len == '0) ? ST_CLEAR : ST_RUN;
                end
            end
            ST_RUN: begin
                rem_d = rem_q - LEN_ONE;
                // A step taken from the top gray code rolls the counter over to zero.
                if (Cnt_val == GRAY_TOP && wrap_cnt_q != '1) begin
                    wrap_cnt_d = wrap_cnt_q + LEN_ONE;
                end
                if (rem_q == LEN_ONE) begin
                    state_d   = ST_FINISH;
                    done_id_d = id_q;
                    wraps_d   = wrap_cnt_d;
                end
            end
            ST_CLEAR: begin
                state_d   = ST_FINISH;
                done_id_d = id_q;
                wraps_d   = wrap_cnt_q;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            id_q       <= 1'b0;
            wrap_cnt_q <= '0;
            done_id_q  <= 1'b0;
            wraps_q    <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            id_q       <= id_d;
            wrap_cnt_q <= wrap_cnt_d;
            done_id_q  <= done_id_d;
            wraps_q    <= wraps_d;
        end
    end

    assign Cnt_en  = (state_q == ST_RUN);
    assign Cnt_clr = (state_q == ST_CLEAR);
    assign Busy    = (state_q != ST_IDLE);
    assign Done    = (state_q == ST_FINISH);
    assign Done_id = done_id_q;
    assign Wraps   = wraps_q;

endmodule
